// File: rtl/llc_ctrl_regfile_pkg.sv
// Shared constants and types for the LLC control register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package llc_ctrl_regfile_pkg;

   // MSHR sizing; the counter must hold 0..LLC_N_MSHR inclusive.
   localparam int LLC_N_MSHR       = 4;
   localparam int LLC_MSHR_BITS_P1 = $clog2(LLC_N_MSHR + 1);

   // Control flag count and bit positions inside the flag vector.
   localparam int LLC_N_CTRL_FLAGS         = 5;
   localparam int LLC_FLG_EVICT_STALL      = 0;
   localparam int LLC_FLG_SET_CONFLICT     = 1;
   localparam int LLC_FLG_REQ_IN_STALLED_V = 2;
   localparam int LLC_FLG_UPDATE_EVICT_WAY = 3;
   localparam int LLC_FLG_SPARE            = 4;

   // Default decode-time auto-clear: only update_evict_way.
   localparam logic [LLC_N_CTRL_FLAGS-1:0] LLC_DECODE_CLR_MASK_DFLT =
      LLC_N_CTRL_FLAGS'(1) << LLC_FLG_UPDATE_EVICT_WAY;

   // Named view of the default flag vector (MSB first = highest index).
   typedef struct packed {
      logic spare;
      logic update_evict_way;
      logic req_in_stalled_valid;
      logic set_conflict;
      logic evict_stall;
   } llc_ctrl_flags_t;

endpackage

// File: rtl/llc_sc_flag.sv
// Single set/clear control flop; clear beats set.
// Latency: a pulse in cycle N is visible at q in cycle N+1.
// Backpressure: none; set/clr are level-sampled every cycle.
module llc_sc_flag #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic set,
   input  logic clr,
   output logic q
);

   // Reset, then clear, then set, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst)      q <= RST_VAL;
      else if (clr) q <= 1'b0;
      else if (set) q <= 1'b1;
   end

endmodule

// File: rtl/llc_ctrl_regfile.sv
// LLC control register file: set/clear flags, saturating MSHR credits, low watermark.
// Latency: every trigger is visible on the outputs one cycle later; outputs are registered.
// Backpressure: none; dropped allocs/frees hold the count (sticky errors with LLC_CTRL_REGFILE_ERR_EN).
module llc_ctrl_regfile
   import llc_ctrl_regfile_pkg::*;
#(
   parameter int                  N_FLAGS         = LLC_N_CTRL_FLAGS,
   parameter int                  N_MSHR          = LLC_N_MSHR,
   parameter int                  CNT_W           = $clog2(N_MSHR + 1),
   parameter logic [N_FLAGS-1:0]  FLAG_RST_VAL    = '0,
   parameter logic [N_FLAGS-1:0]  DECODE_CLR_MASK = N_FLAGS'(LLC_DECODE_CLR_MASK_DFLT)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               decode_en,
   input  logic [N_FLAGS-1:0] flag_set,
   input  logic [N_FLAGS-1:0] flag_clr,
   input  logic               mshr_alloc,
   input  logic               mshr_free,
   input  logic               wm_clr,
`ifdef LLC_CTRL_REGFILE_ERR_EN
   input  logic               err_clr,
   output logic               err_underflow,
   output logic               err_overflow,
`endif
   output logic [N_FLAGS-1:0] flags,
   output logic [CNT_W-1:0]   mshr_cnt,
   output logic               mshr_none_free,
   output logic               mshr_all_free,
   output logic [CNT_W-1:0]   mshr_low_wm
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(N_MSHR);

   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] wm_nxt;
   logic             alloc_only;
   logic             free_only;

   // One independent set/clear flop per flag; decode_en folds into the clear.
   for (genvar i = 0; i < N_FLAGS; i++) begin : g_flag
      llc_sc_flag #(
         .RST_VAL (FLAG_RST_VAL[i])
      ) u_flag (
         .clk (clk),
         .rst (rst),
         .set (flag_set[i]),
         .clr (flag_clr[i] | (decode_en & DECODE_CLR_MASK[i])),
         .q   (flags[i])
      );
   end

   assign alloc_only = mshr_alloc & ~mshr_free;
   assign free_only  = mshr_free & ~mshr_alloc;

   // Saturating credit update; simultaneous alloc+free is net zero, even at the bounds.
   always_comb begin
      cnt_nxt = mshr_cnt;
      if (alloc_only && (mshr_cnt != '0))
         cnt_nxt = mshr_cnt - CNT_W'(1);
      else if (free_only && (mshr_cnt != FULL))
         cnt_nxt = mshr_cnt + CNT_W'(1);
   end

   // Watermark tracks the post-update count so wm_clr+alloc lands on the new value.
   always_comb begin
      wm_nxt = mshr_low_wm;
      if (wm_clr)                    wm_nxt = cnt_nxt;
      else if (cnt_nxt < mshr_low_wm) wm_nxt = cnt_nxt;
   end

   // Counter and watermark registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         mshr_cnt    <= FULL;
         mshr_low_wm <= FULL;
      end else begin
         mshr_cnt    <= cnt_nxt;
         mshr_low_wm <= wm_nxt;
      end
   end

   // Status decodes look only at the registered count.
   assign mshr_none_free = (mshr_cnt == '0);
   assign mshr_all_free  = (mshr_cnt == FULL);

`ifdef LLC_CTRL_REGFILE_ERR_EN
   logic underflow_evt;
   logic overflow_evt;

   assign underflow_evt = alloc_only & (mshr_cnt == '0);
   assign overflow_evt  = free_only & (mshr_cnt == FULL);

   // Sticky errors; a new event in the same cycle as err_clr keeps the bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_underflow <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         err_underflow <= underflow_evt | (err_underflow & ~err_clr);
         err_overflow  <= overflow_evt  | (err_overflow  & ~err_clr);
      end
   end

`ifndef SYNTHESIS
   // The controller should never issue an alloc with no credit or a surplus free.
   a_no_credit_err: assert property (@(posedge clk) disable iff (rst)
                                     !(underflow_evt || overflow_evt));
`endif
`endif

endmodule

// File: doc/llc_ctrl_regfile.md
# llc_ctrl_regfile

Parametrised control-register file for the Spandex LLC. It holds an arbitrary number of set/clear stall and status flags and the MSHR credit counter, and the LLC controller FSM drives it with one-cycle trigger pulses. Compared with the fixed five-register bank it replaces, it adds:
- configurable flag count and reset values;
- a decode-time auto-clear mask;
- correct handling of simultaneous MSHR allocate and free;
- bounded credit arithmetic and a low-watermark monitor;
- optional sticky error reporting.

## Interface
Parameters:
- N_FLAGS, 5, number of set/clear flag registers; bit order is evict_stall, set_conflict, req_in_stalled_valid, update_evict_way, spare.
- N_MSHR, `N_MSHR, MSHR entries; the counter's full-credit value.
- CNT_W, $clog2(N_MSHR+1), counter width; equals `MSHR_BITS_P1 at the default.
- FLAG_RST_VAL, '0, N_FLAGS-bit reset value of the flags.
- DECODE_CLR_MASK, 5'b01000, flags cleared by decode_en (default clears update_evict_way only).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous and active-high.
- decode_en  in  1  decode pulse; clears the flags selected by DECODE_CLR_MASK.
- flag_set  in  N_FLAGS  per-flag set pulse.
- flag_clr  in  N_FLAGS  per-flag clear pulse.
- mshr_alloc  in  1  consume one MSHR credit.
- mshr_free  in  1  return one MSHR credit.
- wm_clr  in  1  re-arm the low watermark.
- err_clr  in  1  clear the sticky errors (present only with the macro).
- flags  out  N_FLAGS  flag registers.
- mshr_cnt  out  CNT_W  free MSHR credits.
- mshr_none_free  out  1  mshr_cnt == 0.
- mshr_all_free  out  1  mshr_cnt == N_MSHR.
- mshr_low_wm  out  CNT_W  minimum mshr_cnt since reset or the last wm_clr.
- err_underflow, err_overflow  out  1 each  sticky errors (present only with the macro).

## Operation
- Per-flag priority, evaluated at each rising clk edge:
  - rst: load FLAG_RST_VAL[i];
  - else if flag_clr[i], or decode_en with DECODE_CLR_MASK[i] set: load 0;
  - else if flag_set[i]: load 1;
  - else hold.
- Flags are independent of one another. Set and clear in the same cycle resolve to clear.
- MSHR counter, next-state rules:
  - rst: load N_MSHR.
  - alloc and free together: hold. This is a net-zero change and applies even when the count is 0 or N_MSHR.
  - alloc only, cnt > 0: decrement.
  - alloc only, cnt == 0: hold; the alloc is dropped and counts as an underflow event.
  - free only, cnt < N_MSHR: increment.
  - free only, cnt == N_MSHR: hold; the free is dropped and counts as an overflow event.
- Arithmetic is CNT_W-bit unsigned. The counter never wraps.
- Low watermark:
  - rst: load N_MSHR.
  - wm_clr: load the counter's next-state value.
  - otherwise: load min(mshr_low_wm, counter next-state).
  - wm_clr together with alloc: the watermark takes the post-alloc value.
- mshr_none_free and mshr_all_free are decoded combinationally from the mshr_cnt register only; they have no input-to-output combinational path.
- Sticky errors (macro builds only):
  - an underflow event sets err_underflow; an overflow event sets err_overflow;
  - err_clr clears both;
  - an event in the same cycle as err_clr wins, so the bit is left set;
  - rst clears both.

## Timing
- Every output comes from a register or from a decode of registered state. A trigger pulse in cycle N is visible in cycle N+1.
- Reset values:
  - flags = FLAG_RST_VAL;
  - mshr_cnt = N_MSHR, mshr_low_wm = N_MSHR;
  - mshr_none_free = 0, mshr_all_free = 1;
  - err_* = 0.
- Reset asserted mid-operation overrides every trigger in that cycle. Triggers are level-sampled each cycle, so a pulse held high for k cycles acts k times.
- Inputs must be synchronous to clk. There is no handshake; the controller must not rely on a dropped alloc having taken effect.

## Configuration
- LLC_CTRL_REGFILE_ERR_EN:
  - defined: err_clr, err_underflow, err_overflow and their logic are present. An SVA assertion (under synthesis translate_off) fires on any underflow or overflow event.
  - undefined: those ports and that logic are absent. The saturating hold behaviour is unchanged.

## Structure
- Shared constants live in spandex_consts.svh: `N_MSHR and `MSHR_BITS_P1.
- Add `LLC_N_CTRL_FLAGS and the flag index constants (`LLC_FLG_EVICT_STALL, etc.) to spandex_consts.svh.
- Add a packed llc_ctrl_flags_t typedef to spandex_types.svh.
- Sub-module llc_sc_flag: a single set/clear flop with parameter RST_VAL, instantiated N_FLAGS times in a generate loop.
- The counter and watermark stay in the top module.

## Test plan
All scenarios use N_MSHR=4, N_FLAGS=5 and the default mask.
- Reset, then idle 3 cycles -> flags=00000, mshr_cnt=4, all_free=1, none_free=0, low_wm=4.
- Five alloc pulses -> cnt 3,2,1,0,0; none_free=1 from cycle 4; low_wm=0; err_underflow=1 on the 5th pulse (macro builds).
- At cnt=2, alloc and free together for 3 cycles -> cnt stays 2. Repeat at cnt=0 and at cnt=4 -> the count holds and no error is set.
- flag_set=01100, then decode_en -> flags=00100. flag_set[1] and flag_clr[1] together -> flags[1]=0.
- From cnt=4: alloc twice, free twice, then wm_clr -> low_wm=2 before the clear and 4 after it.
- Free at cnt=4 -> cnt=4 and err_overflow=1. err_clr together with a second overflow -> err_overflow stays 1. err_clr alone -> 0. rst asserted mid-burst -> every output returns to its reset value next cycle.
